reserve_station: RTL and testbench

Out-of-order reservation station for the integer ALU path. It accepts decoded instructions from the issue stage and holds each one until both source operands are known. Operands are captured from the two CDB ports: the ALU port and the LSB port. Each cycle it dispatches at most one ready instruction, as a registered one-cycle request carrying the full operand bundle to the ALU.

---
 rtl/reserve_station_pkg.sv | 56 +++++
 rtl/reserve_station_if.sv | 54 +++++
 rtl/reserve_station_select.sv | 23 ++
 rtl/reserve_station.sv | 124 ++++++++++++
 tb/tb_reserve_station.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reserve_station_pkg.sv
// Shared types and constants for the integer ALU reservation station.
// Holds the datapath widths, entry geometry, opcode encodings, the entry record
// and the CDB snoop helper used by both issue-time forwarding and wakeup.
package reserve_station_pkg;

    localparam int unsigned OperatorWidth = 6;
    localparam int unsigned DataWidth     = 32;
    localparam int unsigned AddressWidth  = 32;
    localparam int unsigned RobWidth      = 4;
    localparam int unsigned RsSize        = 16;
    localparam int unsigned RsIdxW        = 4;

    localparam logic [OperatorWidth-1:0] OpAdd  = 6'd1;
    localparam logic [OperatorWidth-1:0] OpSub  = 6'd2;
    localparam logic [OperatorWidth-1:0] OpAddi = 6'd3;

    typedef struct packed {
        logic                 ready;
        logic [DataWidth-1:0] val;
        logic [RobWidth-1:0]  tag;
    } operand_t;

    typedef struct packed {
        logic [OperatorWidth-1:0] op_type;
        logic [AddressWidth-1:0]  pc;
        logic [DataWidth-1:0]     imm;
        operand_t                 rs;
        operand_t                 rt;
        logic [RobWidth-1:0]      reorder;
    } rs_entry_t;

    // Resolve a pending operand against both CDB ports; the ALU port wins a tie.
    function automatic operand_t cdb_snoop(
        input operand_t             cur,
        input logic                 alu_en,
        input logic [RobWidth-1:0]  alu_tag,
        input logic [DataWidth-1:0] alu_res,
        input logic                 lsb_en,
        input logic [RobWidth-1:0]  lsb_tag,
        input logic [DataWidth-1:0] lsb_res
    );
        operand_t res;
        res = cur;
        if (!cur.ready) begin
            if (alu_en && alu_tag == cur.tag) begin
                res.ready = 1'b1;
                res.val   = alu_res;
            end else if (lsb_en && lsb_tag == cur.tag) begin
                res.ready = 1'b1;
                res.val   = lsb_res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reserve_station_if.sv
// Issue, CDB and ALU-dispatch bus of the reservation station.
// slave: the station (consumes issue + CDB, drives out_alu_*).
// master: the surrounding pipeline / bench.
interface reserve_station_if;
    import reserve_station_pkg::*;

    logic                     in_issue_enable;
    logic [OperatorWidth-1:0] in_issue_type;
    logic [AddressWidth-1:0]  in_issue_pc;
    logic [DataWidth-1:0]     in_issue_imm;
    logic                     in_issue_rs_ready;
    logic                     in_issue_rt_ready;
    logic [DataWidth-1:0]     in_issue_rs_val;
    logic [DataWidth-1:0]     in_issue_rt_val;
    logic [RobWidth-1:0]      in_issue_rs_tag;
    logic [RobWidth-1:0]      in_issue_rt_tag;
    logic [RobWidth-1:0]      in_issue_reorder;

    logic                     in_alu_cdb_enable;
    logic [RobWidth-1:0]      in_alu_cdb_reorder;
    logic [DataWidth-1:0]     in_alu_cdb_result;
    logic                     in_lsb_cdb_enable;
    logic [RobWidth-1:0]      in_lsb_cdb_reorder;
    logic [DataWidth-1:0]     in_lsb_cdb_result;

    logic                     out_alu_enable;
    logic [OperatorWidth-1:0] out_alu_type;
    logic [AddressWidth-1:0]  out_alu_pc;
    logic [DataWidth-1:0]     out_alu_imm;
    logic [DataWidth-1:0]     out_alu_rs;
    logic [DataWidth-1:0]     out_alu_rt;
    logic [RobWidth-1:0]      out_alu_reorder;

    modport slave (
        input  in_issue_enable, in_issue_type, in_issue_pc, in_issue_imm,
               in_issue_rs_ready, in_issue_rt_ready, in_issue_rs_val, in_issue_rt_val,
               in_issue_rs_tag, in_issue_rt_tag, in_issue_reorder,
               in_alu_cdb_enable, in_alu_cdb_reorder, in_alu_cdb_result,
               in_lsb_cdb_enable, in_lsb_cdb_reorder, in_lsb_cdb_result,
        output out_alu_enable, out_alu_type, out_alu_pc, out_alu_imm,
               out_alu_rs, out_alu_rt, out_alu_reorder
    );

    modport master (
        output in_issue_enable, in_issue_type, in_issue_pc, in_issue_imm,
               in_issue_rs_ready, in_issue_rt_ready, in_issue_rs_val, in_issue_rt_val,
               in_issue_rs_tag, in_issue_rt_tag, in_issue_reorder,
               in_alu_cdb_enable, in_alu_cdb_reorder, in_alu_cdb_result,
               in_lsb_cdb_enable, in_lsb_cdb_reorder, in_lsb_cdb_result,
        input  out_alu_enable, out_alu_type, out_alu_pc, out_alu_imm,
               out_alu_rs, out_alu_rt, out_alu_reorder
    );

endinterface

// File: rtl/reserve_station_select.sv
// Combinational lowest-index priority encoder.
// req_i: request vector; found_o: any request set; idx_o: lowest set index (0 if none).
module reserve_station_select #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] req_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/reserve_station.sv
// Reservation station for the integer ALU path.
// in_clk/in_rst: clock and synchronous active-low reset.
// in_rdy: global stall when low; in_clear: misprediction flush.
// bus: issue input, ALU/LSB CDB snoop, registered one-cycle ALU dispatch.
// out_full: every entry busy.
module reserve_station
    import reserve_station_pkg::*;
(
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_rdy,
    input  logic                in_clear,
    reserve_station_if.slave    bus,
    output logic                out_full
);

    rs_entry_t                entry_q [RsSize];
    rs_entry_t                entry_d [RsSize];
    logic [RsSize-1:0]        busy_q, busy_d;
    logic                     alu_en_q, alu_en_d;
    rs_entry_t                alu_q, alu_d;

    logic [RsSize-1:0]        ready_req;
    logic                     free_found, ready_found;
    logic [RsIdxW-1:0]        free_idx, ready_idx;
    operand_t                 issue_rs, issue_rt;

    // Selection sees only registered state, so same-edge issue/wakeup never dispatches.
    always_comb begin
        for (int i = 0; i < RsSize; i++) begin
            ready_req[i] = busy_q[i] & entry_q[i].rs.ready & entry_q[i].rt.ready;
        end
    end

    reserve_station_select #(.N(RsSize), .W(RsIdxW)) u_free_sel (
        .req_i   (~busy_q),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    reserve_station_select #(.N(RsSize), .W(RsIdxW)) u_ready_sel (
        .req_i   (ready_req),
        .found_o (ready_found),
        .idx_o   (ready_idx)
    );

    assign out_full = &busy_q;

    always_comb begin
        issue_rs = cdb_snoop(
            '{ready: bus.in_issue_rs_ready, val: bus.in_issue_rs_val, tag: bus.in_issue_rs_tag},
            bus.in_alu_cdb_enable, bus.in_alu_cdb_reorder, bus.in_alu_cdb_result,
            bus.in_lsb_cdb_enable, bus.in_lsb_cdb_reorder, bus.in_lsb_cdb_result);
        issue_rt = cdb_snoop(
            '{ready: bus.in_issue_rt_ready, val: bus.in_issue_rt_val, tag: bus.in_issue_rt_tag},
            bus.in_alu_cdb_enable, bus.in_alu_cdb_reorder, bus.in_alu_cdb_result,
            bus.in_lsb_cdb_enable, bus.in_lsb_cdb_reorder, bus.in_lsb_cdb_result);
    end

    always_comb begin
        entry_d  = entry_q;
        busy_d   = busy_q;
        alu_d    = alu_q;
        alu_en_d = 1'b0;

        if (!in_rdy) begin
            // Frozen; only the dispatch strobe drops.
        end else if (in_clear) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < RsSize; i++) begin
                if (busy_q[i]) begin
                    entry_d[i].rs = cdb_snoop(entry_q[i].rs,
                        bus.in_alu_cdb_enable, bus.in_alu_cdb_reorder, bus.in_alu_cdb_result,
                        bus.in_lsb_cdb_enable, bus.in_lsb_cdb_reorder, bus.in_lsb_cdb_result);
                    entry_d[i].rt = cdb_snoop(entry_q[i].rt,
                        bus.in_alu_cdb_enable, bus.in_alu_cdb_reorder, bus.in_alu_cdb_result,
                        bus.in_lsb_cdb_enable, bus.in_lsb_cdb_reorder, bus.in_lsb_cdb_result);
                end
            end

            if (ready_found) begin
                alu_d             = entry_q[ready_idx];
                alu_en_d          = 1'b1;
                busy_d[ready_idx] = 1'b0;
            end

            // free_idx comes from busy_q, so a slot freed this edge is not reused until the next.
            if (bus.in_issue_enable && free_found) begin
                entry_d[free_idx] = '{
                    op_type: bus.in_issue_type,
                    pc:      bus.in_issue_pc,
                    imm:     bus.in_issue_imm,
                    rs:      issue_rs,
                    rt:      issue_rt,
                    reorder: bus.in_issue_reorder
                };
                busy_d[free_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            busy_q   <= '0;
            alu_en_q <= 1'b0;
            alu_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            alu_en_q <= alu_en_d;
            alu_q    <= alu_d;
            entry_q  <= entry_d;
        end
    end

    assign bus.out_alu_enable  = alu_en_q;
    assign bus.out_alu_type    = alu_q.op_type;
    assign bus.out_alu_pc      = alu_q.pc;
    assign bus.out_alu_imm     = alu_q.imm;
    assign bus.out_alu_rs      = alu_q.rs.val;
    assign bus.out_alu_rt      = alu_q.rt.val;
    assign bus.out_alu_reorder = alu_q.reorder;

endmodule

// File: tb/tb_reserve_station.sv
// Directed bench for reserve_station: reset, ready issue, wakeup, issue-time
// forwarding (incl. ALU-over-LSB tie), fill/full/drop/drain, flush, stall, mid-op reset.
module tb_reserve_station;
    import reserve_station_pkg::*;

    logic in_clk = 1'b0;
    logic in_rst;
    logic in_rdy;
    logic in_clear;
    logic out_full;
    int   n_tests = 0;
    int   n_fail  = 0;

    reserve_station_if bus ();

    reserve_station dut (
        .in_clk   (in_clk),
        .in_rst   (in_rst),
        .in_rdy   (in_rdy),
        .in_clear (in_clear),
        .bus      (bus),
        .out_full (out_full)
    );

    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic idle();
        bus.in_issue_enable   = 1'b0;
        bus.in_alu_cdb_enable = 1'b0;
        bus.in_lsb_cdb_enable = 1'b0;
    endtask

    task automatic set_issue(
        input logic [5:0]  op,
        input logic [31:0] pc,
        input logic        rs_rdy,
        input logic [31:0] rs_val,
        input logic [3:0]  rs_tag,
        input logic        rt_rdy,
        input logic [31:0] rt_val,
        input logic [3:0]  rt_tag,
        input logic [3:0]  reorder
    );
        bus.in_issue_enable   = 1'b1;
        bus.in_issue_type     = op;
        bus.in_issue_pc       = pc;
        bus.in_issue_imm      = pc ^ 32'h5a5a_0000;
        bus.in_issue_rs_ready = rs_rdy;
        bus.in_issue_rs_val   = rs_val;
        bus.in_issue_rs_tag   = rs_tag;
        bus.in_issue_rt_ready = rt_rdy;
        bus.in_issue_rt_val   = rt_val;
        bus.in_issue_rt_tag   = rt_tag;
        bus.in_issue_reorder  = reorder;
    endtask

    task automatic set_alu_cdb(input logic [3:0] tag, input logic [31:0] val);
        bus.in_alu_cdb_enable  = 1'b1;
        bus.in_alu_cdb_reorder = tag;
        bus.in_alu_cdb_result  = val;
    endtask

    task automatic set_lsb_cdb(input logic [3:0] tag, input logic [31:0] val);
        bus.in_lsb_cdb_enable  = 1'b1;
        bus.in_lsb_cdb_reorder = tag;
        bus.in_lsb_cdb_result  = val;
    endtask

    initial begin
        int n_disp;
        in_rst   = 1'b0;
        in_rdy   = 1'b1;
        in_clear = 1'b0;
        set_issue(6'd0, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0);
        set_alu_cdb(4'd0, 32'd0);
        set_lsb_cdb(4'd0, 32'd0);
        idle();

        // Reset
        tick();
        tick();
        check("rst_en", 32'(bus.out_alu_enable), 32'd0);
        check("rst_full", 32'(out_full), 32'd0);
        check("rst_rs", bus.out_alu_rs, 32'd0);
        check("rst_pc", bus.out_alu_pc, 32'd0);
        check("rst_reorder", 32'(bus.out_alu_reorder), 32'd0);
        in_rst = 1'b1;
        tick();

        // ADD with both operands ready
        set_issue(OpAdd, 32'h100, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
        tick();
        idle();
        check("add_no_early", 32'(bus.out_alu_enable), 32'd0);
        tick();
        check("add_en", 32'(bus.out_alu_enable), 32'd1);
        check("add_rs", bus.out_alu_rs, 32'd5);
        check("add_rt", bus.out_alu_rt, 32'd7);
        check("add_reorder", 32'(bus.out_alu_reorder), 32'd3);
        check("add_type", 32'(bus.out_alu_type), 32'(OpAdd));
        check("add_imm", bus.out_alu_imm, 32'h5a5a_0100);
        check("add_full", 32'(out_full), 32'd0);
        tick();
        check("add_one_pulse", 32'(bus.out_alu_enable), 32'd0);
        check("add_hold_rs", bus.out_alu_rs, 32'd5);

        // SUB waiting on tag 2, woken by ALU CDB
        set_issue(OpSub, 32'h104, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0, 4'd4);
        tick();
        idle();
        tick();
        tick();
        check("sub_wait", 32'(bus.out_alu_enable), 32'd0);
        set_alu_cdb(4'd2, 32'h10);
        tick();
        idle();
        check("sub_wake_edge", 32'(bus.out_alu_enable), 32'd0);
        tick();
        check("sub_en", 32'(bus.out_alu_enable), 32'd1);
        check("sub_rs", bus.out_alu_rs, 32'h10);
        check("sub_rt", bus.out_alu_rt, 32'd1);
        check("sub_reorder", 32'(bus.out_alu_reorder), 32'd4);

        // ADDI forwarded at issue: rs from LSB tag 6, rt from ALU tag 8
        set_issue(OpAddi, 32'h108, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd8, 4'd5);
        set_lsb_cdb(4'd6, 32'hAB);
        set_alu_cdb(4'd8, 32'h11);
        tick();
        idle();
        tick();
        check("addi_en", 32'(bus.out_alu_enable), 32'd1);
        check("addi_rs", bus.out_alu_rs, 32'hAB);
        check("addi_rt", bus.out_alu_rt, 32'h11);
        check("addi_type", 32'(bus.out_alu_type), 32'(OpAddi));

        // Both ports match the same tag: ALU result must win
        set_issue(OpAdd, 32'h10c, 1'b0, 32'd0, 4'd9, 1'b1, 32'd2, 4'd0, 4'd6);
        set_alu_cdb(4'd9, 32'h11);
        set_lsb_cdb(4'd9, 32'h22);
        tick();
        idle();
        tick();
        check("tie_en", 32'(bus.out_alu_enable), 32'd1);
        check("tie_rs", bus.out_alu_rs, 32'h11);

        // Fill all entries; entry 0 waits on tag 1, others on tag 9
        for (int i = 0; i < 16; i++) begin
            set_issue(OpAdd, 32'(32'h200 + 4 * i), 1'b0, 32'd0, (i == 0) ? 4'd1 : 4'd9,
                      1'b1, 32'(i), 4'd0, 4'(i));
            tick();
            if (i == 14) check("fill_15_not_full", 32'(out_full), 32'd0);
        end
        check("fill_full", 32'(out_full), 32'd1);
        // 17th issue, ready operands: must be dropped
        set_issue(OpAdd, 32'hDEAD, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd0);
        tick();
        idle();
        tick();
        tick();
        check("drop_no_disp", 32'(bus.out_alu_enable), 32'd0);
        check("drop_full", 32'(out_full), 32'd1);
        set_alu_cdb(4'd1, 32'h55);
        tick();
        idle();
        check("e0_wake_full", 32'(out_full), 32'd1);
        tick();
        check("e0_en", 32'(bus.out_alu_enable), 32'd1);
        check("e0_pc", bus.out_alu_pc, 32'h200);
        check("e0_rs", bus.out_alu_rs, 32'h55);
        check("e0_full_fall", 32'(out_full), 32'd0);
        // Drain the remaining 15 back to back
        set_alu_cdb(4'd9, 32'h99);
        tick();
        idle();
        n_disp = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.out_alu_enable) begin
                n_disp++;
                check("drain_pc", bus.out_alu_pc, 32'(32'h200 + 4 * n_disp));
            end
        end
        check("drain_count", 32'(n_disp), 32'd15);
        check("drain_empty", 32'(out_full), 32'd0);

        // Flush: 4 pending entries plus one ready entry dispatchable at the clear edge
        for (int i = 0; i < 4; i++) begin
            set_issue(OpSub, 32'(32'h280 + 4 * i), 1'b0, 32'd0, 4'd11, 1'b1, 32'd0, 4'd0, 4'(i));
            tick();
        end
        set_issue(OpAdd, 32'h2c0, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd12);
        tick();
        set_issue(OpAdd, 32'h2c4, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd13);
        in_clear = 1'b1;
        tick();
        in_clear = 1'b0;
        idle();
        check("clr_en", 32'(bus.out_alu_enable), 32'd0);
        set_alu_cdb(4'd11, 32'h77);
        tick();
        idle();
        n_disp = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.out_alu_enable) n_disp++;
        end
        check("clr_no_disp", 32'(n_disp), 32'd0);

        // Stall: ready entry held while in_rdy=0, issue during stall ignored
        set_issue(OpAdd, 32'h300, 1'b1, 32'h33, 4'd0, 1'b1, 32'h44, 4'd0, 4'd7);
        tick();
        in_rdy = 1'b0;
        set_issue(OpAdd, 32'h400, 1'b1, 32'h1, 4'd0, 1'b1, 32'h1, 4'd0, 4'd8);
        n_disp = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.out_alu_enable) n_disp++;
        end
        check("stall_no_disp", 32'(n_disp), 32'd0);
        idle();
        in_rdy = 1'b1;
        tick();
        check("stall_rel_en", 32'(bus.out_alu_enable), 32'd1);
        check("stall_rel_pc", bus.out_alu_pc, 32'h300);
        check("stall_rel_rs", bus.out_alu_rs, 32'h33);
        tick();
        check("stall_no_dup", 32'(bus.out_alu_enable), 32'd0);

        // Reset while an entry is about to dispatch
        set_issue(OpSub, 32'h500, 1'b1, 32'h9, 4'd0, 1'b1, 32'h8, 4'd0, 4'd9);
        tick();
        idle();
        in_rst = 1'b0;
        tick();
        check("mrst_en", 32'(bus.out_alu_enable), 32'd0);
        check("mrst_pc", bus.out_alu_pc, 32'd0);
        in_rst = 1'b1;
        tick();
        tick();
        check("mrst_discard", 32'(bus.out_alu_enable), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
